// File: rtl/des_job_arbiter.sv
// Round-robin arbiter that shares one DES engine among NUM_REQ requesters.
// Drives the engine handshake, routes results back, and aborts stuck jobs.
module des_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [64*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_ed,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [63:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    eng_ready,
  output logic [63:0]             eng_data_in,
  output logic                    eng_ed_sel,
  input  logic                    eng_next_data,
  input  logic                    eng_done,
  input  logic [63:0]             eng_data_out,
  output logic                    busy
);

  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int WDOG_W  = $clog2(TIMEOUT);
  localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NUM_REQ - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  logic [OWNER_W-1:0]  rr_ptr;
  logic [OWNER_W-1:0]  owner;
  logic [WDOG_W-1:0]   wdog;
  logic [63:0]         job_data;
  logic                job_ed;

  logic                pick_found;
  logic [OWNER_W-1:0]  pick_idx;
  logic [OWNER_W-1:0]  cand;
  logic [63:0]         pick_data;
  logic                pick_ed;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [NUM_REQ-1:0]  owner_onehot;

  // Scanning from the far end down lets the last hit be the first requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = OWNER_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    pick_ed   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == OWNER_W'(i)) begin
        pick_data = req_data[64*i +: 64];
        pick_ed   = req_ed[i];
      end
    end
  end

  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  // Job data is captured on the same edge that raises req_grant, so later requester changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      wdog        <= '0;
      job_data    <= '0;
      job_ed      <= 1'b0;
      req_grant   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      eng_ready   <= 1'b0;
      eng_data_in <= '0;
      eng_ed_sel  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner     <= pick_idx;
            job_data  <= pick_data;
            job_ed    <= pick_ed;
            rr_ptr    <= (pick_idx == LAST_REQ) ? '0 : pick_idx + 1'b1;
            req_grant <= pick_onehot;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          eng_ready   <= 1'b1;
          eng_data_in <= job_data;
          eng_ed_sel  <= job_ed;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (eng_next_data) begin
            eng_ready <= 1'b0;
            wdog      <= '0;
            state     <= WAIT;
          end
        end
        // A completion on the final watchdog cycle still counts as success.
        WAIT: begin
          if (eng_done) begin
            rsp_data  <= eng_data_out;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_onehot;
            state     <= RESP;
          end else if (wdog == WDOG_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_onehot;
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
